// File: rtl/iob_ram_rd_stream_pkg.sv
// iob_ram_rd_stream_pkg: shared FSM encoding and stream buffer depth
package iob_ram_rd_stream_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
    localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/iob_ram_at2p.sv
// iob_ram_at2p: dual-clock two-port RAM with registered read data
module iob_ram_at2p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              w_clk_i,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              r_clk_i,
    input  logic              r_en_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [DATA_W-1:0] r_data_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // write port
    always_ff @(posedge w_clk_i) if (w_en_i) mem[w_addr_i] <= w_data_i;

    // read port, data available the cycle after the enable
    always_ff @(posedge r_clk_i) if (r_en_i) r_data_o <= mem[r_addr_i];
endmodule

// File: rtl/iob_ram_rd_stream_buf.sv
// iob_ram_rd_stream_buf: 2-entry in-order buffer with simultaneous push/pop
module iob_ram_rd_stream_buf
    import iob_ram_rd_stream_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   level_o
);
    logic [W-1:0] mem [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    assign data_o = mem[rd_ptr];

    // storage, pointers and occupancy; push and pop in one cycle keep level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            level_o <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_i) rd_ptr <= ~rd_ptr;
            level_o <= level_o + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/iob_ram_rd_stream.sv
// iob_ram_rd_stream: reads a burst of RAM words and streams them out with backpressure
module iob_ram_rd_stream
    import iob_ram_rd_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              r_en_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);
    localparam logic [1:0]    DEPTH = 2'(BUF_DEPTH);
    localparam logic [ADDR_W:0] ONE = 1;

    state_t          state;
    logic [ADDR_W:0] rem;
    logic            r_last;
    logic            pend;
    logic            pend_last;
    logic            xfer;
    logic            room;
    logic [1:0]      level;
    logic [1:0]      level_nxt;
    logic [DATA_W:0] head;
    logic            has_buf;

    // buffered words come first; otherwise the word arriving from RAM is passed straight through
    assign has_buf   = level != 2'd0;
    assign m_valid_o = has_buf | pend;
    assign m_data_o  = has_buf ? head[DATA_W-1:0] : pend ? r_data_i : '0;
    assign m_last_o  = has_buf ? head[DATA_W] : pend & pend_last;
    assign xfer      = m_valid_o & m_ready_i;
    assign level_nxt = level + 2'(pend) - 2'(xfer);
    assign room      = (level_nxt + 2'(r_en_o)) < DEPTH;

    iob_ram_rd_stream_buf #(.W(DATA_W + 1)) u_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (pend),
        .pop_i  (xfer),
        .data_i ({pend_last, r_data_i}),
        .data_o (head),
        .level_o(level)
    );

    // burst control: issue reads while buffer room allows, finish on the last transfer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rem       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            r_en_o    <= 1'b0;
            r_addr_o  <= '0;
            r_last    <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            r_en_o    <= 1'b0;
            pend      <= r_en_o;
            pend_last <= r_en_o & r_last;
            case (state)
                IDLE: if (start_i) begin
                    if (len_i != '0) begin
                        state    <= READ;
                        busy_o   <= 1'b1;
                        r_en_o   <= 1'b1;
                        r_addr_o <= base_addr_i;
                        r_last   <= len_i == ONE;
                        rem      <= len_i - ONE;
                    end else done_o <= 1'b1;
                end
                READ: if (rem == '0) state <= DRAIN;
                    else if (room) begin
                        r_en_o   <= 1'b1;
                        r_addr_o <= r_addr_o + ADDR_W'(1);
                        r_last   <= rem == ONE;
                        rem      <= rem - ONE;
                    end
                DRAIN: if (xfer && m_last_o) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_ram_rd_stream.sv
// tb_iob_ram_rd_stream: directed checks of the RAM read streamer against a registered-read RAM
module tb_iob_ram_rd_stream;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [3:0] base_addr_i;
    logic [4:0] len_i;
    logic       busy_o, done_o, r_en_o, m_valid_o, m_last_o, m_ready_i;
    logic [3:0] r_addr_o;
    logic [7:0] r_data_i, m_data_o;
    logic       w_en;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    iob_ram_rd_stream dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .r_en_o(r_en_o), .r_addr_o(r_addr_o), .r_data_i(r_data_i),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i)
    );

    iob_ram_at2p ram (
        .w_clk_i(clk_i), .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
        .r_clk_i(clk_i), .r_en_i(r_en_o), .r_addr_i(r_addr_o), .r_data_o(r_data_i)
    );

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        n_checks += 7;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy_o); end
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0d want 0", done_o); end
        if (r_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_r_en got %0d want 0", r_en_o); end
        if (r_addr_o !== 4'd0) begin n_fail++; $display("FAIL reset_r_addr got %0d want 0", r_addr_o); end
        if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0d want 0", m_valid_o); end
        if (m_data_o !== 8'd0) begin n_fail++; $display("FAIL reset_m_data got %0d want 0", m_data_o); end
        if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_m_last got %0d want 0", m_last_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        n_checks += 2;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %0d want 0", busy_o); end
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_done got %0d want 0", done_o); end
    endtask

    task automatic fill_ram;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            w_en = 1'b1;
            w_addr = 4'(i);
            w_data = 8'(32 + i);
        end
        @(negedge clk_i);
        w_en = 1'b0;
    endtask

    task automatic test_full_stream;
        @(negedge clk_i);
        base_addr_i = 4'd0; len_i = 5'd16; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        n_checks += 4;
        if (r_en_o !== 1'b1) begin n_fail++; $display("FAIL full_first_r_en got %0d want 1", r_en_o); end
        if (r_addr_o !== 4'd0) begin n_fail++; $display("FAIL full_first_addr got %0d want 0", r_addr_o); end
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL full_busy got %0d want 1", busy_o); end
        if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %0d want 0", m_valid_o); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            #1;
            n_checks += 4;
            if (m_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_valid[%0d] got %0d want 1", k, m_valid_o); end
            if (m_data_o !== 8'(32 + k)) begin n_fail++; $display("FAIL full_data[%0d] got %0d want %0d", k, m_data_o, 32 + k); end
            if (m_last_o !== (k == 15)) begin n_fail++; $display("FAIL full_last[%0d] got %0d want %0d", k, m_last_o, k == 15); end
            if (done_o !== 1'b0) begin n_fail++; $display("FAIL full_early_done[%0d] got %0d want 0", k, done_o); end
        end
        @(negedge clk_i);
        #1;
        n_checks += 3;
        if (done_o !== 1'b1) begin n_fail++; $display("FAIL full_done got %0d want 1", done_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_busy_drop got %0d want 0", busy_o); end
        if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_valid_after got %0d want 0", m_valid_o); end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse got %0d want 0", done_o); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_d [4] = '{8'd46, 8'd47, 8'd32, 8'd33};
        logic [3:0] exp_a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        @(negedge clk_i);
        base_addr_i = 4'd14; len_i = 5'd4; start_i = 1'b1; m_ready_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            if (c <= 4) begin
                n_checks += 2;
                if (r_en_o !== 1'b1) begin n_fail++; $display("FAIL wrap_r_en[%0d] got %0d want 1", c, r_en_o); end
                if (r_addr_o !== exp_a[c-1]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %0d want %0d", c, r_addr_o, exp_a[c-1]); end
            end else begin
                n_checks++;
                if (r_en_o !== 1'b0) begin n_fail++; $display("FAIL wrap_r_en_idle[%0d] got %0d want 0", c, r_en_o); end
            end
            if (c >= 2 && c <= 5) begin
                n_checks += 2;
                if (m_data_o !== exp_d[c-2] || m_valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap_data[%0d] got %0d/v%0d want %0d", c, m_data_o, m_valid_o, exp_d[c-2]); end
                if (m_last_o !== (c == 5)) begin n_fail++; $display("FAIL wrap_last[%0d] got %0d want %0d", c, m_last_o, c == 5); end
            end
            if (c == 6) begin
                n_checks++;
                if (done_o !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %0d want 1", done_o); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat = 4'b1001;
        int idx = 0;
        int issued = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        bit seen_done = 0;
        @(negedge clk_i);
        base_addr_i = 4'd0; len_i = 5'd8; start_i = 1'b1; m_ready_i = pat[0];
        for (int c = 1; c < 80 && !seen_done; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            m_ready_i = pat[c % 4];
            #1;
            if (prev_stall) begin
                n_checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== prev_data) begin n_fail++; $display("FAIL bp_hold[%0d] got %0d/v%0d want %0d", c, m_data_o, m_valid_o, prev_data); end
            end
            if (r_en_o) begin
                n_checks += 2;
                if (r_addr_o !== 4'(issued)) begin n_fail++; $display("FAIL bp_addr[%0d] got %0d want %0d", c, r_addr_o, issued); end
                issued++;
                if (issued - idx > 2) begin n_fail++; $display("FAIL bp_outstanding[%0d] got %0d want <=2", c, issued - idx); end
            end
            if (m_valid_o && m_ready_i) begin
                n_checks += 2;
                if (m_data_o !== 8'(32 + idx)) begin n_fail++; $display("FAIL bp_data[%0d] got %0d want %0d", idx, m_data_o, 32 + idx); end
                if (m_last_o !== (idx == 7)) begin n_fail++; $display("FAIL bp_last[%0d] got %0d want %0d", idx, m_last_o, idx == 7); end
                idx++;
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data = m_data_o;
            if (done_o) begin
                seen_done = 1;
                n_checks++;
                if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_busy_at_done got %0d want 0", busy_o); end
            end
        end
        n_checks += 2;
        if (!seen_done) begin n_fail++; $display("FAIL bp_done_timeout got 0 want 1"); end
        if (idx != 8 || issued != 8) begin n_fail++; $display("FAIL bp_count got %0d/%0d want 8/8", idx, issued); end
        m_ready_i = 1'b1;
    endtask

    task automatic test_zero_len;
        @(negedge clk_i);
        base_addr_i = 4'd5; len_i = 5'd0; start_i = 1'b1; m_ready_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            n_checks += 4;
            if (done_o !== (c == 1)) begin n_fail++; $display("FAIL zero_done[%0d] got %0d want %0d", c, done_o, c == 1); end
            if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_busy[%0d] got %0d want 0", c, busy_o); end
            if (r_en_o !== 1'b0) begin n_fail++; $display("FAIL zero_r_en[%0d] got %0d want 0", c, r_en_o); end
            if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_valid[%0d] got %0d want 0", c, m_valid_o); end
        end
    endtask

    task automatic test_ignore_start;
        @(negedge clk_i);
        base_addr_i = 4'd0; len_i = 5'd16; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            start_i = (k == 1);
            if (k == 1) begin base_addr_i = 4'd8; len_i = 5'd4; end
            #1;
            n_checks += 2;
            if (m_valid_o !== 1'b1 || m_data_o !== 8'(32 + k)) begin n_fail++; $display("FAIL ign_data[%0d] got %0d/v%0d want %0d", k, m_data_o, m_valid_o, 32 + k); end
            if (m_last_o !== (k == 15)) begin n_fail++; $display("FAIL ign_last[%0d] got %0d want %0d", k, m_last_o, k == 15); end
            if (k == 2) begin
                n_checks++;
                if (r_addr_o !== 4'd3) begin n_fail++; $display("FAIL ign_addr got %0d want 3", r_addr_o); end
            end
        end
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        n_checks++;
        if (done_o !== 1'b1) begin n_fail++; $display("FAIL ign_done got %0d want 1", done_o); end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset_mid;
        @(negedge clk_i);
        base_addr_i = 4'd0; len_i = 5'd16; start_i = 1'b1; m_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            #1;
            n_checks++;
            if (m_data_o !== 8'(32 + k)) begin n_fail++; $display("FAIL rst_pre_data[%0d] got %0d want %0d", k, m_data_o, 32 + k); end
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        n_checks += 7;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0d want 0", busy_o); end
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %0d want 0", done_o); end
        if (r_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_r_en got %0d want 0", r_en_o); end
        if (r_addr_o !== 4'd0) begin n_fail++; $display("FAIL rst_mid_addr got %0d want 0", r_addr_o); end
        if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %0d want 0", m_valid_o); end
        if (m_data_o !== 8'd0) begin n_fail++; $display("FAIL rst_mid_data got %0d want 0", m_data_o); end
        if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last got %0d want 0", m_last_o); end
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            n_checks += 2;
            if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_done[%0d] got %0d want 0", c, done_o); end
            if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_valid[%0d] got %0d want 0", c, m_valid_o); end
        end
        @(negedge clk_i);
        base_addr_i = 4'd3; len_i = 5'd2; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        n_checks++;
        if (r_en_o !== 1'b1 || r_addr_o !== 4'd3) begin n_fail++; $display("FAIL rst_new_addr got %0d/e%0d want 3", r_addr_o, r_en_o); end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'd35 || m_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_new_w0 got %0d/l%0d want 35/l0", m_data_o, m_last_o); end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 8'd36 || m_last_o !== 1'b1) begin n_fail++; $display("FAIL rst_new_w1 got %0d/l%0d want 36/l1", m_data_o, m_last_o); end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (done_o !== 1'b1) begin n_fail++; $display("FAIL rst_new_done got %0d want 1", done_o); end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
        w_en = 1'b0; w_addr = '0; w_data = '0;
        test_reset();
        fill_ram();
        test_full_stream();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_ignore_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
